split_result_collector: RTL and testbench

Downstream stage of the `split` datapath: captures each 6-bit `result` word that `split` produces into a small in-order FIFO and releases the words to a consumer over a valid/ready handshake. It also keeps a saturating running sum of every accepted word. It is the first sequential element after the combinational `split` block and turns its free-running output into a flow-controlled stream.

---
 rtl/split_pkg.sv | 18 +
 rtl/split_sat_acc.sv | 66 ++++++
 rtl/split_result_collector.sv | 84 ++++++++
 tb/tb_split_result_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared definitions for the split datapath and its result collector.
package split_pkg;

  // Result width of the combinational split block.
  localparam int unsigned SPLIT_WIDTH       = 6;
  // Collector defaults.
  localparam int unsigned COLLECT_DEPTH     = 4;
  localparam int unsigned COLLECT_SUM_WIDTH = 10;

  // Accumulator action for one cycle.
  typedef enum logic [1:0] {
    ACC_HOLD  = 2'd0,  // no push, no clear
    ACC_ADD   = 2'd1,  // push: saturating add
    ACC_CLEAR = 2'd2,  // clear without push
    ACC_LOAD  = 2'd3   // clear with push: restart from the pushed word
  } acc_op_e;

endpackage

// File: rtl/split_sat_acc.sv
// Saturating running sum of accepted words with a sticky clip flag.
module split_sat_acc
  import split_pkg::*;
#(
  parameter int unsigned WIDTH     = SPLIT_WIDTH,
  parameter int unsigned SUM_WIDTH = COLLECT_SUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 clear_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic                 sum_sat_o
);

  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                 sat_q, sat_d;
  logic [SUM_WIDTH:0]   sum_ext;
  logic                 clip;
  acc_op_e              op;

  // Decode the cycle's action and form the next sum with one guard bit.
  always_comb begin
    op      = ACC_HOLD;
    sum_d   = sum_q;
    sat_d   = sat_q;
    sum_ext = {1'b0, sum_q} + (SUM_WIDTH + 1)'(data_i);
    clip    = sum_ext[SUM_WIDTH];

    if (clear_i && push_i)  op = ACC_LOAD;
    else if (clear_i)       op = ACC_CLEAR;
    else if (push_i)        op = ACC_ADD;

    unique case (op)
      ACC_ADD: begin
        sum_d = clip ? '1 : sum_ext[SUM_WIDTH-1:0];
        sat_d = sat_q | clip;
      end
      ACC_CLEAR: begin
        sum_d = '0;
        sat_d = 1'b0;
      end
      ACC_LOAD: begin
        sum_d = SUM_WIDTH'(data_i);
        sat_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Accumulator registers; reset overrides clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      sat_q <= sat_d;
    end
  end

  assign sum_o     = sum_q;
  assign sum_sat_o = sat_q;

endmodule

// File: rtl/split_result_collector.sv
// In-order FIFO behind the split block with valid/ready output and running sum.
module split_result_collector
  import split_pkg::*;
#(
  parameter int unsigned WIDTH     = SPLIT_WIDTH,
  parameter int unsigned DEPTH     = COLLECT_DEPTH,
  parameter int unsigned SUM_WIDTH = COLLECT_SUM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [SUM_WIDTH-1:0]     sum,
  output logic                     sum_sat
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Handshake from registered occupancy only; pointers and count next state.
  always_comb begin
    in_ready  = (count_q != FULL);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // FIFO state and storage; reset wipes every entry so the idle head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  split_sat_acc #(
    .WIDTH     (WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .clear_i   (clear),
    .data_i    (in_data),
    .sum_o     (sum),
    .sum_sat_o (sum_sat)
  );

endmodule

// File: tb/tb_split_result_collector.sv
// Bench for split_result_collector: queue-based model plus directed literal checks.
module tb_split_result_collector;

  localparam int DEPTH = 4;
  localparam int SMAX  = 1023;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, clear;
  logic [5:0] in_data;
  logic       in_ready, out_valid, sum_sat;
  logic [5:0] out_data;
  logic [2:0] count;
  logic [9:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: contents in order, sum as plain integer.
  int q[$];
  int m_sum = 0;
  bit m_sat = 1'b0;
  bit m_push, m_pop;

  always #5 clk = ~clk;

  split_result_collector #(
    .WIDTH     (6),
    .DEPTH     (DEPTH),
    .SUM_WIDTH (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .clear     (clear),
    .count     (count),
    .sum       (sum),
    .sum_sat   (sum_sat)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: evaluates the handshake rules on the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_sum = 0;
      m_sat = 1'b0;
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = out_ready && (q.size() > 0);
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(int'(in_data));
      if (clear) begin
        m_sum = m_push ? int'(in_data) : 0;
        m_sat = 1'b0;
      end else if (m_push) begin
        m_sum = m_sum + int'(in_data);
        if (m_sum > SMAX) begin
          m_sum = SMAX;
          m_sat = 1'b1;
        end
      end
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    check("count", int'(count), q.size());
    check("in_ready", int'(in_ready), int'(q.size() != DEPTH));
    check("out_valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) check("out_data", int'(out_data), q[0]);
    check("sum", int'(sum), m_sum);
    check("sum_sat", int'(sum_sat), int'(m_sat));
  end

  task automatic step(input bit v, input int d, input bit r, input bit c);
    in_valid  = v;
    in_data   = 6'(d);
    out_ready = r;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int exp_words[$]);
    foreach (exp_words[i]) begin
      check({name, "_valid"}, int'(out_valid), 1);
      check({name, "_data"}, int'(out_data), exp_words[i]);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    check({name, "_empty"}, int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 6'd9; out_ready = 1'b0; clear = 1'b0;

    // Reset with a pending push
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_sum_sat", int'(sum_sat), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);
    check("rst_nothing_stored", int'(count), 0);

    // Ordered fill then drain
    step(1'b1, 5, 1'b0, 1'b0);
    check("lat1_valid", int'(out_valid), 1);
    check("lat1_data", int'(out_data), 5);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 12, 1'b0, 1'b0);
    check("fill_count", int'(count), 3);
    check("fill_head", int'(out_data), 5);
    check("fill_sum", int'(sum), 26);
    drain("fill_drain", '{5, 9, 12});

    // Full boundary
    step(1'b0, 0, 1'b0, 1'b1);
    check("clr_sum", int'(sum), 0);
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    check("full_in_ready", int'(in_ready), 0);
    check("full_count", int'(count), 4);
    check("full_sum", int'(sum), 10);
    step(1'b1, 7, 1'b0, 1'b0);
    check("held_count", int'(count), 4);
    check("held_sum", int'(sum), 10);
    check("pop_cycle_in_ready", int'(in_ready), 0);
    step(1'b1, 7, 1'b1, 1'b0);
    check("after_pop_in_ready", int'(in_ready), 1);
    check("after_pop_count", int'(count), 3);
    check("after_pop_sum", int'(sum), 10);
    step(1'b1, 7, 1'b0, 1'b0);
    check("refill_count", int'(count), 4);
    check("refill_sum", int'(sum), 17);
    drain("wrap_drain", '{2, 3, 4, 7});

    // Simultaneous push and pop at occupancy 2
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0);
    check("pp_pre_head", int'(out_data), 3);
    step(1'b1, 8, 1'b1, 1'b0);
    check("pp_count", int'(count), 2);
    drain("pp_drain", '{6, 8});

    // Saturation and clear
    step(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 63, 1'b1, 1'b0);
    check("sat16_sum", int'(sum), 1008);
    check("sat16_flag", int'(sum_sat), 0);
    step(1'b1, 63, 1'b1, 1'b0);
    check("sat17_sum", int'(sum), 1023);
    check("sat17_flag", int'(sum_sat), 1);
    step(1'b0, 0, 1'b1, 1'b1);
    check("clr_sum0", int'(sum), 0);
    check("clr_flag0", int'(sum_sat), 0);
    step(1'b1, 8, 1'b1, 1'b1);
    check("clr_push_sum", int'(sum), 8);
    check("clr_push_flag", int'(sum_sat), 0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Mid-operation reset
    for (int i = 1; i <= 3; i++) step(1'b1, i, 1'b0, 1'b0);
    check("mid_count", int'(count), 3);
    rst = 1'b1;
    step(1'b1, 5, 1'b1, 1'b0);
    rst = 1'b0;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_sum", int'(sum), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    step(1'b1, 4, 1'b0, 1'b0);
    check("mid_push_valid", int'(out_valid), 1);
    check("mid_push_data", int'(out_data), 4);

    // Randomized traffic, checked by the compare process each cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step(($urandom_range(0, 3) != 0),
           (i % 500 < 250) ? $urandom_range(40, 63) : $urandom_range(0, 63),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
